// File: rtl/wbm_cmd_pkg.sv
// wbm_cmd_pkg: shared types and constants for the Wishbone command initiator.
//   state_e    : initiator FSM states (IDLE, BUS, RESP)
//   ST_*       : rsp_status encodings
//   TO_W       : width of the optional wait/timeout counter
package wbm_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam int TO_W = 16;

endpackage

// File: rtl/wbm_timeout_cnt.sv
// wbm_timeout_cnt: wait-state counter for one Wishbone cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count at zero (entry into the bus phase)
//   en         : count one more cycle with no ack/err
//   limit      : timeout value in cycles (1..65535)
//   expired    : count has reached limit-1, i.e. this is the last allowed cycle
module wbm_timeout_cnt
    import wbm_cmd_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Count 0 is the first bus cycle, so limit-1 marks cycle number 'limit'.
    assign expired = (cnt == limit - 1'b1);

endmodule

// File: rtl/wbm_cmd_initiator.sv
// wbm_cmd_initiator: Wishbone classic-cycle master, one command at a time.
//   cmd_*      : valid/ready command in (we, adr, dat, sel)
//   rsp_*      : valid/ready response out (dat, status: 00 OK, 01 ERR, 11 TIMEOUT)
//   wbm_*      : Wishbone master bus (cyc, stb, we, sel, adr, dat_o / dat_i, ack, err)
// Optional: define WBM_TIMEOUT_EN to abort a cycle after TIMEOUT bus cycles
// with no ack/err. Without it the bus phase waits indefinitely.
// All outputs are registered; cmd_ready is high exactly in IDLE.
module wbm_cmd_initiator
    import wbm_cmd_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic [1:0]          rsp_status,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wbm_cmd_initiator: TIMEOUT out of range 1..65535");
    end

    state_e state;
    logic   accept;
    logic   in_bus;
    logic   timed_out;

    // cmd_ready is only ever high in IDLE, so this is the IDLE handshake.
    assign accept = cmd_valid & cmd_ready;
    assign in_bus = (state == BUS);

`ifdef WBM_TIMEOUT_EN
    logic expired;

    wbm_timeout_cnt u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (in_bus & ~wbm_ack_i & ~wbm_err_i),
        .limit   (TO_W'(TIMEOUT)),
        .expired (expired)
    );

    // A bus response in the expiry cycle takes priority over the abort.
    assign timed_out = in_bus & expired & ~wbm_ack_i & ~wbm_err_i;
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // err dominates ack; writes never return bus data.
                    if (wbm_err_i || wbm_ack_i || timed_out) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (wbm_err_i) begin
                            rsp_dat    <= '0;
                            rsp_status <= ST_ERR;
                        end else if (wbm_ack_i) begin
                            rsp_dat    <= wbm_we_o ? '0 : wbm_dat_i;
                            rsp_status <= ST_OK;
                        end else begin
                            rsp_dat    <= '0;
                            rsp_status <= ST_TIMEOUT;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/wbm_cmd_initiator.md
Name: wbm_cmd_initiator

Overview:
- Wishbone classic-cycle master that lets user-area logic issue single reads and writes into a Wishbone responder, such as the user project slave port or a peer peripheral.
- Accepts one command at a time on a valid/ready command interface.
- Drives one Wishbone cycle per command, then returns read data and a status on a valid/ready response interface.
- Non-pipelined; at most one transaction outstanding.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; sel width is DATA_W/8.
- TIMEOUT, 255, cycles to wait for ack/err before abort (used only with WBM_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  ADDR_W  target address.
- cmd_dat  in  DATA_W  write data.
- cmd_sel  in  DATA_W/8  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_dat  out  DATA_W  read data (0 for writes).
- rsp_status  out  2  00=OK, 01=ERR, 11=TIMEOUT.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  DATA_W/8  byte selects.
- wbm_adr_o  out  ADDR_W  address.
- wbm_dat_o  out  DATA_W  write data.
- wbm_dat_i  in  DATA_W  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error.

Behaviour:
- Reset: while rst_n=0 at a clock edge, the following are cleared at that edge: state=IDLE; cyc, stb, we, cmd_ready, rsp_valid=0; sel, adr, dat_o, rsp_dat, rsp_status=0. Because reset is synchronous, a mid-transaction reset drops cyc/stb at the next edge with no response generated.
- Outputs: all registered. cmd_ready=1 exactly in IDLE (registered state decode).
- FSM: IDLE -> BUS -> RESP -> IDLE.
- IDLE: on cmd_valid&cmd_ready, capture we/adr/dat/sel into the wbm_* registers, assert cyc=stb=1, go to BUS.
- BUS: cyc, stb, we, sel, adr, dat_o are held stable.
  - ack=1: deassert cyc/stb next edge; rsp_dat = wbm_dat_i if read, else 0; status=00; rsp_valid=1; go to RESP.
  - err=1: same as ack, but rsp_dat=0 and status=01.
  - ack and err both 1: err wins.
  - ack/err sampled only in BUS; ignored in IDLE and RESP.
- RESP: rsp_valid, rsp_dat, rsp_status held until rsp_ready. On handshake: rsp_valid=0, go to IDLE.
- Latency: command accepted at edge N gives stb high in cycle N+1. A zero-wait-state ack in cycle N+1 gives rsp_valid in cycle N+2. Minimum 3 cycles per transaction; no back-to-back overlap.
- Between transactions, wbm_adr/dat/sel/we keep their last values; only cyc/stb return to 0.

Optional Feature:
- WBM_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When the count reaches TIMEOUT-1 with no ack/err, the transaction aborts: cyc/stb drop next edge; rsp_dat=0; status=11; go to RESP.
  - ack or err in the expiry cycle wins over timeout.
- Not defined: no counter; BUS waits indefinitely; status 11 is never produced.

Decomposition:
- Package wbm_cmd_pkg: state enum (IDLE, BUS, RESP); status constants ST_OK=2'b00, ST_ERR=2'b01, ST_TIMEOUT=2'b11; counter width constant TO_W=16.
- Sub-module wbm_timeout_cnt: inputs clk, rst_n, clr, en, limit; output expired. Instantiated only under WBM_TIMEOUT_EN.

Test Plan:
- Write, zero-wait: cmd we=1, adr=0x3000_0004, dat=0x0000_0015, sel=4'hF; responder acks in the first stb cycle -> wbm_* fields match the command; stb high 1 cycle; rsp_valid 2 cycles after accept; status=00; rsp_dat=0.
- Read, 3 wait states: responder returns 0x0000_0007 -> stb held 4 cycles with adr stable; rsp_dat=0x0000_0007; status=00.
- Error: ack and err both asserted in the same cycle -> status=01; rsp_dat=0; cyc=0 the next cycle.
- Response backpressure: rsp_ready held 0 for 5 cycles with cmd_valid held 1 -> rsp_valid, rsp_dat, rsp_status stable; cmd_ready=0 until the cycle after the rsp handshake; second command then accepted.
- Timeout (WBM_TIMEOUT_EN, TIMEOUT=4), no ack -> stb high exactly 4 cycles; status=11. Variant with ack in the 4th cycle -> status=00.
- Reset mid-BUS: rst_n=0 for one edge while stb=1 -> cyc, stb, rsp_valid=0 after that edge; state IDLE; cmd_ready=1 once rst_n=1; no stale response.
